des_perm_pipe: RTL and testbench

Parametrised, pipelined DES bit-permutation engine. It replaces the fixed single-table combinational permutation wires with one elastic unit that supports four DES permutations, each selectable per transaction. The unit sits between the round datapath and the key/IO logic. It accepts one 64-bit word per cycle under valid/ready flow control and returns the permuted word after a configurable number of register stages.

---
 rtl/des_perm_if.sv | 22 ++
 rtl/des_perm_pipe.sv | 172 +++++++++++++++++
 tb/tb_des_perm_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_perm_if.sv
// Valid/ready stream bundle for the DES permutation pipeline.
// Words use DES bit numbering: bit 64 of the vector is DES bit 1.
interface des_perm_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [64:1] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_mode;
  logic [64:1] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
endinterface

// File: rtl/des_perm_pipe.sv
// Elastic, STAGES-deep DES permutation pipeline (P, P^-1, IP, FP selectable per word).
// Define DES_PERM_CHECK_EN to compile in the inverse-permutation self-check driving chk_err.

// Pure wiring network: out bit i = in bit T[i], DES numbering.
module des_perm_net (
  input  logic [1:0]  mode,
  input  logic [64:1] data,
  output logic [64:1] perm
);
  localparam int P_TBL [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PI_TBL [32] = '{9, 17, 23, 31, 13, 28, 2, 18, 24, 16, 30, 6, 26, 20, 10, 1,
                                 8, 14, 25, 3, 4, 29, 11, 19, 32, 12, 22, 7, 5, 27, 15, 21};
  localparam int IP_TBL [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_TBL [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  logic [32:1] p_fwd;
  logic [32:1] p_inv;
  logic [64:1] ip;
  logic [64:1] fp;

  // DES bit k of an n-bit word lives at vector index n+1-k.
  for (genvar i = 1; i <= 32; i++) begin : g_p32
    assign p_fwd[33-i] = data[33-P_TBL[i-1]];
    assign p_inv[33-i] = data[33-PI_TBL[i-1]];
  end

  for (genvar i = 1; i <= 64; i++) begin : g_p64
    assign ip[65-i] = data[65-IP_TBL[i-1]];
    assign fp[65-i] = data[65-FP_TBL[i-1]];
  end

  always_comb begin
    case (mode)
      2'd0:    perm = {32'd0, p_fwd};
      2'd1:    perm = {32'd0, p_inv};
      2'd2:    perm = ip;
      default: perm = fp;
    endcase
  end
endmodule

module des_perm_pipe #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  des_perm_if.slave  bus,
  output logic       chk_err
);
  logic [64:1]       perm_data;
  logic              accept;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] src_valid;
  logic [1:0]        mode_q   [STAGES];
  logic [1:0]        src_mode [STAGES];
  logic [64:1]       data_q   [STAGES];
  logic [64:1]       src_data [STAGES];

  des_perm_net u_fwd (
    .mode (bus.in_mode),
    .data (bus.in_data),
    .perm (perm_data)
  );

  // A stage holds only if it and every stage downstream of it is full and the sink stalls.
  for (genvar k = 0; k < STAGES; k++) begin : g_hold
    assign hold[k] = !bus.out_ready && (&valid_q[STAGES-1:k]);
  end

  assign bus.in_ready = !hold[0] && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every combinational output is given a value on every path, so no latch is inferred.
    src_valid[0] = accept;
    src_mode[0]  = bus.in_mode;
    src_data[0]  = perm_data;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  // NOTE: data/mode registers are reset too, so the output bus reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        mode_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its predecessor's old value.
      for (int k = 0; k < STAGES; k++) begin
        if (!hold[k]) begin
          valid_q[k] <= src_valid[k];
          mode_q[k]  <= src_mode[k];
          data_q[k]  <= src_data[k];
        end
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_mode  = mode_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

`ifdef DES_PERM_CHECK_EN
  logic [64:1] orig_q   [STAGES];
  logic [64:1] src_orig [STAGES];
  logic [64:1] inv_data;
  logic        mismatch;

  always_comb begin
    src_orig[0] = bus.in_data;
    for (int k = 1; k < STAGES; k++) begin
      src_orig[k] = orig_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        orig_q[k] <= '0;
      end
    end else if (!flush) begin
      for (int k = 0; k < STAGES; k++) begin
        if (!hold[k]) begin
          orig_q[k] <= src_orig[k];
        end
      end
    end
  end

  // Flipping mode bit 0 selects the inverse table: P<->P^-1, IP<->FP.
  des_perm_net u_inv (
    .mode (bus.out_mode ^ 2'b01),
    .data (bus.out_data),
    .perm (inv_data)
  );

  always_comb begin
    if (bus.out_mode[1]) begin
      mismatch = (inv_data != orig_q[STAGES-1]);
    end else begin
      mismatch = (inv_data[32:1] != orig_q[STAGES-1][32:1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && mismatch) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed-vector and randomized-stream bench for des_perm_pipe (STAGES = 2, 1 and 4 instances).
module tb_des_perm_pipe;
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PI_T [32] = '{9, 17, 23, 31, 13, 28, 2, 18, 24, 16, 30, 6, 26, 20, 10, 1,
                               8, 14, 25, 3, 4, 29, 11, 19, 32, 12, 22, 7, 5, 27, 15, 21};
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_r = 1'b0;
  logic chk_a, chk_1, chk_4;

  logic        r_valid = 1'b0;
  logic [1:0]  r_mode  = '0;
  logic [63:0] r_data  = '0;
  logic        rdy1    = 1'b1;
  logic        rdy4    = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int n_out1 = 0;
  int n_out4 = 0;

  logic [65:0] q1[$];
  logic [65:0] q4[$];
  logic [65:0] e1, e4;
  logic        stall1 = 1'b0, stall4 = 1'b0;
  logic [63:0] held1, held4;

  vec_t vecs [11];

  des_perm_if bus_a ();
  des_perm_if bus_1 ();
  des_perm_if bus_4 ();

  des_perm_pipe #(.STAGES(2)) u_dut (.clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a), .chk_err(chk_a));
  des_perm_pipe #(.STAGES(1)) u_s1  (.clk(clk), .rst_n(rst_n), .flush(flush_r), .bus(bus_1), .chk_err(chk_1));
  des_perm_pipe #(.STAGES(4)) u_s4  (.clk(clk), .rst_n(rst_n), .flush(flush_r), .bus(bus_4), .chk_err(chk_4));

  assign bus_1.in_valid  = r_valid;
  assign bus_1.in_mode   = r_mode;
  assign bus_1.in_data   = r_data;
  assign bus_1.out_ready = rdy1;
  assign bus_4.in_valid  = r_valid;
  assign bus_4.in_mode   = r_mode;
  assign bus_4.in_data   = r_data;
  assign bus_4.out_ready = rdy4;

  always #5 clk = ~clk;

  // Reference permutation: out DES bit i = in DES bit T[i], built with shifts.
  function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 1; i <= 32; i++) begin
      if (m == 2'd0) r = r | (((d >> (32 - P_T[i-1])) & 64'd1) << (32 - i));
      if (m == 2'd1) r = r | (((d >> (32 - PI_T[i-1])) & 64'd1) << (32 - i));
    end
    for (int i = 1; i <= 64; i++) begin
      if (m == 2'd2) r = r | (((d >> (64 - IP_T[i-1])) & 64'd1) << (64 - i));
      if (m == 2'd3) r = r | (((d >> (64 - FP_T[i-1])) & 64'd1) << (64 - i));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream scoreboards for the STAGES=1 and STAGES=4 instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_1.out_valid && bus_1.out_ready) begin
        n_out1++;
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s1_dup: got %h, expected no word", bus_1.out_data);
        end else begin
          e1 = q1.pop_front();
          check("s1_data", bus_1.out_data, e1[63:0]);
          check("s1_mode", 64'(bus_1.out_mode), 64'(e1[65:64]));
        end
      end
      if (stall1) check("s1_stable", bus_1.out_data, held1);
      stall1 = bus_1.out_valid && !bus_1.out_ready;
      held1  = bus_1.out_data;
      if (bus_1.in_valid && bus_1.in_ready) q1.push_back({bus_1.in_mode, model(bus_1.in_mode, bus_1.in_data)});

      if (bus_4.out_valid && bus_4.out_ready) begin
        n_out4++;
        if (q4.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s4_dup: got %h, expected no word", bus_4.out_data);
        end else begin
          e4 = q4.pop_front();
          check("s4_data", bus_4.out_data, e4[63:0]);
          check("s4_mode", 64'(bus_4.out_mode), 64'(e4[65:64]));
        end
      end
      if (stall4) check("s4_stable", bus_4.out_data, held4);
      stall4 = bus_4.out_valid && !bus_4.out_ready;
      held4  = bus_4.out_data;
      if (bus_4.in_valid && bus_4.in_ready) q4.push_back({bus_4.in_mode, model(bus_4.in_mode, bus_4.in_data)});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen;

    vecs[0]  = '{2'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0800};
    vecs[1]  = '{2'd1, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0001};
    vecs[2]  = '{2'd2, 64'h0000_0000_0000_0001, 64'h0000_0080_0000_0000};
    vecs[3]  = '{2'd3, 64'h0000_0080_0000_0000, 64'h0000_0000_0000_0001};
    vecs[4]  = '{2'd0, 64'h0000_0000_8000_0000, 64'h0000_0000_0080_0000};
    vecs[5]  = '{2'd1, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080};
    vecs[6]  = '{2'd2, 64'h8000_0000_0000_0000, 64'h0000_0000_0100_0000};
    vecs[7]  = '{2'd3, 64'h0000_0000_0100_0000, 64'h8000_0000_0000_0000};
    vecs[8]  = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[9]  = '{2'd1, 64'hDEAD_BEEF_0000_0800, 64'h0000_0000_0000_0001};
    vecs[10] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    bus_a.in_valid  = 1'b0;
    bus_a.in_mode   = '0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_out_data",  bus_a.out_data, 64'd0);
    check("rst_out_mode",  64'(bus_a.out_mode), 64'd0);
    check("rst_in_ready",  64'(bus_a.in_ready), 64'd1);
    check("rst_chk_err",   64'(chk_a), 64'd0);
    rst_n = 1'b1;

    // Directed vectors through the STAGES=2 instance
    for (int v = 0; v < 11; v++) begin
      @(posedge clk); #1;
      bus_a.in_valid = 1'b1;
      bus_a.in_mode  = vecs[v].mode;
      bus_a.in_data  = vecs[v].din;
      @(negedge clk);
      check("vec_in_ready", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      lat = 0;
      while (lat < 8) begin
        @(negedge clk);
        if (bus_a.out_valid) break;
        @(posedge clk);
        lat++;
      end
      check("vec_latency", 64'(lat), 64'd1);
      check("vec_data", bus_a.out_data, vecs[v].dout);
      check("vec_mode", 64'(bus_a.out_mode), 64'(vecs[v].mode));
    end

    // Fill with out_ready = 0, then flush while offering a word
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'd0;
    bus_a.in_data   = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    bus_a.in_mode   = 2'd1;
    bus_a.in_data   = 64'h0000_0000_0000_0800;
    @(posedge clk); #1;
    bus_a.in_mode   = 2'd2;
    bus_a.in_data   = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check("full_in_ready",  64'(bus_a.in_ready), 64'd0);
    check("full_out_valid", 64'(bus_a.out_valid), 64'd1);
    check("full_out_data",  bus_a.out_data, 64'h0000_0000_0000_0800);
    @(posedge clk); #1;
    check("stall_out_data", bus_a.out_data, 64'h0000_0000_0000_0800);
    flush_a        = 1'b1;
    bus_a.in_mode  = 2'd3;
    bus_a.in_data  = 64'h0F0F_0F0F_0F0F_0F0F;
    @(negedge clk);
    check("flush_in_ready", 64'(bus_a.in_ready), 64'd0);
    @(posedge clk); #1;
    flush_a        = 1'b0;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("post_flush_in_ready",  64'(bus_a.in_ready), 64'd1);
    check("post_flush_data_kept", bus_a.out_data, 64'h0000_0000_0000_0800);
    bus_a.out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus_a.out_valid;
    end
    check("post_flush_no_word", 64'(seen), 64'd0);

    // Randomized streams on the STAGES=1 and STAGES=4 instances
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      r_valid = ($urandom_range(0, 3) != 0);
      r_mode  = 2'($urandom);
      r_data  = {$urandom, $urandom};
      rdy1    = ($urandom_range(0, 2) != 0);
      rdy4    = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    r_valid = 1'b0;
    rdy1    = 1'b1;
    rdy4    = 1'b1;
    repeat (10) @(negedge clk);
    check("s1_drained", 64'(q1.size()), 64'd0);
    check("s4_drained", 64'(q4.size()), 64'd0);
    check("s1_traffic", 64'(n_out1 > 100), 64'd1);
    check("s4_traffic", 64'(n_out4 > 100), 64'd1);

    // Asynchronous reset with a word in flight
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1;
    bus_a.in_mode  = 2'd2;
    bus_a.in_data  = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_valid", 64'(bus_a.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("async_rst_data",  bus_a.out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DES_PERM_CHECK_EN
    // Corrupt the last stage and let the word transfer
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'd0;
    bus_a.in_data   = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    bus_a.in_valid  = 1'b0;
    @(posedge clk); #1;
    force u_dut.data_q[1] = 64'h0000_0000_0000_0801;
    @(negedge clk);
    check("chk_before_xfer", 64'(chk_a), 64'd0);
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    release u_dut.data_q[1];
    @(negedge clk);
    check("chk_set", 64'(chk_a), 64'd1);
    @(posedge clk); #1;
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    @(negedge clk);
    check("chk_sticky_flush", 64'(chk_a), 64'd1);
    check("chk_s1_clean", 64'(chk_1), 64'd0);
    check("chk_s4_clean", 64'(chk_4), 64'd0);
`else
    check("chk_a_zero", 64'(chk_a), 64'd0);
    check("chk_1_zero", 64'(chk_1), 64'd0);
    check("chk_4_zero", 64'(chk_4), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
